// File: rtl/cfg_chain_loader.sv
// Serialises a captured bitstream into a daisy-chained configuration shift chain,
// optionally reshifts it while comparing the chain's readback, then enables the fabric.
module cfg_chain_loader #(
  parameter int unsigned CHAIN_LEN = 69,
  parameter bit          VERIFY    = 1'b1
) (
  input  logic                         prog_clk,
  input  logic                         prog_rst_n,
  input  logic                         cfg_valid,
  input  logic [CHAIN_LEN-1:0]         cfg_data,
  output logic                         cfg_ready,
  input  logic                         cfg_abort,
  output logic                         prog_in,
  output logic                         prog_en,
  input  logic                         prog_out,
  output logic                         cfg_done,
  output logic                         cfg_err,
  output logic [$clog2(CHAIN_LEN)-1:0] err_idx,
  output logic                         clb_en
);

  localparam int unsigned     CntW    = $clog2(CHAIN_LEN);
  localparam logic [CntW-1:0] LastIdx = CntW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {StIdle, StShift, StVerify, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CHAIN_LEN-1:0]   bs_q, bs_d;
  logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                   prog_in_q, prog_in_d;
  logic                   prog_en_q, prog_en_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [CntW-1:0]        idx_q, idx_d;
  logic                   clb_q, clb_d;
  logic                   last_bit;
  logic                   mismatch;

  assign last_bit  = (cnt_q == LastIdx);
  assign cnt_inc   = last_bit ? '0 : cnt_q + CntW'(1);
  assign mismatch  = (prog_out != bs_q[cnt_q]);
  assign cfg_ready = (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    bs_d      = bs_q;
    cnt_d     = cnt_q;
    prog_in_d = 1'b0;
    prog_en_d = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    idx_d     = idx_q;
    clb_d     = clb_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid && !cfg_abort) begin
          state_d   = StShift;
          bs_d      = cfg_data;
          cnt_d     = '0;
          prog_en_d = 1'b1;
          prog_in_d = cfg_data[0];
          err_d     = 1'b0;
          idx_d     = '0;
          clb_d     = 1'b0;
        end
      end
      StShift, StVerify: begin
        if (cfg_abort) begin
          state_d = StIdle;
          err_d   = 1'b1;
          idx_d   = '0;
        end else begin
          // Only the first readback mismatch is recorded.
          if (state_q == StVerify && mismatch && !err_q) begin
            err_d = 1'b1;
            idx_d = cnt_q;
          end
          cnt_d = cnt_inc;
          if (!last_bit || (state_q == StShift && VERIFY)) begin
            if (last_bit) state_d = StVerify;
            prog_en_d = 1'b1;
            prog_in_d = bs_q[cnt_inc];
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
            clb_d   = !err_d;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q   <= StIdle;
      bs_q      <= '0;
      cnt_q     <= '0;
      prog_in_q <= 1'b0;
      prog_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      clb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bs_q      <= bs_d;
      cnt_q     <= cnt_d;
      prog_in_q <= prog_in_d;
      prog_en_q <= prog_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      clb_q     <= clb_d;
    end
  end

  assign prog_in  = prog_in_q;
  assign prog_en  = prog_en_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;
  assign err_idx  = idx_q;
  assign clb_en   = clb_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: an 8-bit verifying instance on a modelled chain
// (ideal, stuck-at-0, one stage short) and a 69-bit load-only instance.
module tb_cfg_chain_loader;

  logic prog_clk;
  logic prog_rst_n;

  logic       a_valid, a_ready, a_abort, a_prog_in, a_prog_en, a_prog_out;
  logic       a_done, a_err, a_clb;
  logic [7:0] a_data;
  logic [2:0] a_idx;

  logic        b_valid, b_ready, b_abort, b_prog_in, b_prog_en, b_prog_out;
  logic        b_done, b_err, b_clb;
  logic [68:0] b_data;
  logic [6:0]  b_idx;

  logic [7:0] chain;
  int         chain_mode;  // 0 ideal 8-stage, 1 stuck at 0, 2 seven stages
  int         nvec = 0;
  int         nerr = 0;

  typedef struct {
    logic [7:0] data;
    int         mode;
    logic       err;
    logic [2:0] idx;
  } vec_t;

  vec_t tbl[7];

  cfg_chain_loader #(.CHAIN_LEN(8), .VERIFY(1'b1)) u_dut_a (
    .prog_clk  (prog_clk),
    .prog_rst_n(prog_rst_n),
    .cfg_valid (a_valid),
    .cfg_data  (a_data),
    .cfg_ready (a_ready),
    .cfg_abort (a_abort),
    .prog_in   (a_prog_in),
    .prog_en   (a_prog_en),
    .prog_out  (a_prog_out),
    .cfg_done  (a_done),
    .cfg_err   (a_err),
    .err_idx   (a_idx),
    .clb_en    (a_clb)
  );

  cfg_chain_loader #(.CHAIN_LEN(69), .VERIFY(1'b0)) u_dut_b (
    .prog_clk  (prog_clk),
    .prog_rst_n(prog_rst_n),
    .cfg_valid (b_valid),
    .cfg_data  (b_data),
    .cfg_ready (b_ready),
    .cfg_abort (b_abort),
    .prog_in   (b_prog_in),
    .prog_en   (b_prog_en),
    .prog_out  (b_prog_out),
    .cfg_done  (b_done),
    .cfg_err   (b_err),
    .err_idx   (b_idx),
    .clb_en    (b_clb)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) if (a_prog_en) chain <= {chain[6:0], a_prog_in};
  assign a_prog_out = (chain_mode == 1) ? 1'b0 : ((chain_mode == 2) ? chain[6] : chain[7]);
  assign b_prog_out = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the stream shifted is the bitstream twice; a chain of length L returns,
  // at verify step j, the bit shifted L edges earlier (or 0 if stuck).
  task automatic model_a(input logic [7:0] d, input int mode,
                         output logic e_err, output logic [2:0] e_idx);
    logic [15:0] s;
    logic        rb;
    s     = {d, d};
    e_err = 1'b0;
    e_idx = 3'd0;
    for (int j = 0; j < 8; j++) begin
      if (mode == 1)      rb = 1'b0;
      else if (mode == 2) rb = s[j + 1];
      else                rb = s[j];
      if (rb != d[j] && !e_err) begin
        e_err = 1'b1;
        e_idx = 3'(j);
      end
    end
  endtask

  // Called at a falling edge with instance A idle.
  task automatic run_a(input logic [7:0] d, input int mode,
                       input logic e_err, input logic [2:0] e_idx);
    chain_mode = mode;
    check("a_ready_idle", 32'(a_ready), 1);
    a_data  = d;
    a_valid = 1'b1;
    @(negedge prog_clk);
    a_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check("a_prog_en", 32'(a_prog_en), 1);
      check("a_prog_in", 32'(a_prog_in), 32'(d[c % 8]));
      check("a_done_low", 32'(a_done), 0);
      check("a_clb_low", 32'(a_clb), 0);
      check("a_ready_busy", 32'(a_ready), 0);
      @(negedge prog_clk);
    end
    check("a_done_pulse", 32'(a_done), 1);
    check("a_en_off", 32'(a_prog_en), 0);
    check("a_err", 32'(a_err), 32'(e_err));
    check("a_idx", 32'(a_idx), 32'(e_idx));
    check("a_clb", 32'(a_clb), 32'(!e_err));
    @(negedge prog_clk);
    check("a_ready_after", 32'(a_ready), 1);
    check("a_done_clear", 32'(a_done), 0);
    check("a_clb_hold", 32'(a_clb), 32'(!e_err));
    check("a_err_hold", 32'(a_err), 32'(e_err));
  endtask

  task automatic run_b(input logic [68:0] d, input int abort_at);
    b_data  = d;
    b_valid = 1'b1;
    @(negedge prog_clk);
    b_valid = 1'b0;
    for (int c = 0; c < 69; c++) begin
      if (c == abort_at) begin
        b_abort = 1'b1;
        @(negedge prog_clk);
        b_abort = 1'b0;
        check("b_abort_en", 32'(b_prog_en), 0);
        check("b_abort_err", 32'(b_err), 1);
        check("b_abort_idx", 32'(b_idx), 0);
        check("b_abort_ready", 32'(b_ready), 1);
        check("b_abort_clb", 32'(b_clb), 0);
        for (int k = 0; k < 4; k++) begin
          check("b_abort_no_done", 32'(b_done), 0);
          @(negedge prog_clk);
        end
        return;
      end
      check("b_prog_en", 32'(b_prog_en), 1);
      check("b_prog_in", 32'(b_prog_in), 32'(d[c]));
      check("b_done_low", 32'(b_done), 0);
      @(negedge prog_clk);
    end
    check("b_done_pulse", 32'(b_done), 1);
    check("b_en_off", 32'(b_prog_en), 0);
    check("b_err", 32'(b_err), 0);
    check("b_clb", 32'(b_clb), 1);
    check("b_ready_in_done", 32'(b_ready), 0);
    @(negedge prog_clk);
    check("b_ready_after", 32'(b_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rd;
    logic [95:0] wide;
    logic        e_err;
    logic [2:0]  e_idx;
    int          rm;

    tbl[0] = '{8'hA5, 0, 1'b0, 3'd0};
    tbl[1] = '{8'hA5, 1, 1'b1, 3'd0};
    tbl[2] = '{8'h01, 2, 1'b1, 3'd0};
    tbl[3] = '{8'h00, 1, 1'b0, 3'd0};
    tbl[4] = '{8'hF0, 1, 1'b1, 3'd4};
    tbl[5] = '{8'hFF, 2, 1'b0, 3'd0};
    tbl[6] = '{8'h03, 2, 1'b1, 3'd1};

    prog_rst_n = 1'b0;
    a_valid = 1'b0; a_abort = 1'b0; a_data = '0;
    b_valid = 1'b0; b_abort = 1'b0; b_data = '0;
    chain_mode = 0;
    #3;
    check("rst_a_ready", 32'(a_ready), 1);
    check("rst_a_en", 32'(a_prog_en), 0);
    check("rst_a_in", 32'(a_prog_in), 0);
    check("rst_a_done", 32'(a_done), 0);
    check("rst_a_err", 32'(a_err), 0);
    check("rst_a_idx", 32'(a_idx), 0);
    check("rst_a_clb", 32'(a_clb), 0);
    check("rst_b_ready", 32'(b_ready), 1);
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    @(negedge prog_clk);

    foreach (tbl[i]) run_a(tbl[i].data, tbl[i].mode, tbl[i].err, tbl[i].idx);

    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom);
      rm = int'($urandom_range(0, 2));
      model_a(rd, rm, e_err, e_idx);
      run_a(rd, rm, e_err, e_idx);
    end

    // cfg_valid held high: re-accept only in the idle cycle after DONE.
    chain_mode = 1;
    a_data  = 8'hA5;
    a_valid = 1'b1;
    @(negedge prog_clk);
    for (int c = 0; c < 16; c++) begin
      check("hold_ready_busy", 32'(a_ready), 0);
      check("hold_en", 32'(a_prog_en), 1);
      @(negedge prog_clk);
    end
    check("hold_done", 32'(a_done), 1);
    check("hold_err1", 32'(a_err), 1);
    chain_mode = 0;
    @(negedge prog_clk);
    check("hold_idle_ready", 32'(a_ready), 1);
    check("hold_idle_en", 32'(a_prog_en), 0);
    check("hold_idle_err", 32'(a_err), 1);
    @(negedge prog_clk);
    a_valid = 1'b0;
    check("hold_reaccept_en", 32'(a_prog_en), 1);
    check("hold_err_cleared", 32'(a_err), 0);
    check("hold_reaccept_ready", 32'(a_ready), 0);
    repeat (16) @(negedge prog_clk);
    check("hold2_done", 32'(a_done), 1);
    check("hold2_err", 32'(a_err), 0);
    check("hold2_clb", 32'(a_clb), 1);
    @(negedge prog_clk);

    // Abort together with valid in idle: nothing accepted.
    a_valid = 1'b1;
    a_abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge prog_clk);
      check("valid_abort_ready", 32'(a_ready), 1);
      check("valid_abort_en", 32'(a_prog_en), 0);
      check("valid_abort_clb", 32'(a_clb), 1);
    end
    a_valid = 1'b0;
    a_abort = 1'b0;
    @(negedge prog_clk);

    // 69-bit load-only instance: full load, abort after 4 shifts, full load again.
    wide = {$urandom, $urandom, $urandom};
    run_b(wide[68:0], -1);
    wide = {$urandom, $urandom, $urandom};
    run_b(wide[68:0], 4);
    wide = {$urandom, $urandom, $urandom};
    run_b(wide[68:0], -1);

    // Asynchronous reset mid-shift.
    chain_mode = 0;
    a_data  = 8'h5A;
    a_valid = 1'b1;
    @(negedge prog_clk);
    a_valid = 1'b0;
    repeat (3) @(negedge prog_clk);
    check("pre_rst_en", 32'(a_prog_en), 1);
    #2;
    prog_rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(a_ready), 1);
    check("mid_rst_en", 32'(a_prog_en), 0);
    check("mid_rst_in", 32'(a_prog_in), 0);
    check("mid_rst_done", 32'(a_done), 0);
    check("mid_rst_err", 32'(a_err), 0);
    check("mid_rst_idx", 32'(a_idx), 0);
    check("mid_rst_clb", 32'(a_clb), 0);
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    @(negedge prog_clk);
    run_a(8'hA5, 0, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Configuration controller that serializes a parallel bitstream into a daisy-chained programmable block. It drives the `prog_in` and `prog_en` shift-chain inputs of connection-box and CLB tiles, optionally reads the chain back through `prog_out` to verify the load, and holds the fabric disabled until configuration completes. It sits between the bitstream source (host/ROM interface) and the tile configuration chain, in the `prog_clk` domain.

## Interface
- `CHAIN_LEN`, 69, number of configuration bits in the chain (≥2)
- `VERIFY`, 1, 1 = perform a readback verify pass after the load; 0 = load only
- `prog_clk`  in  1  configuration clock; all state updates on its rising edge
- `prog_rst_n`  in  1  asynchronous, active-low reset
- `cfg_valid`  in  1  bitstream present on `cfg_data`
- `cfg_data`  in  CHAIN_LEN  bitstream; bit 0 is shifted first
- `cfg_ready`  out  1  controller idle; a transfer is accepted when `cfg_valid` and `cfg_ready` are both high
- `cfg_abort`  in  1  abort the load in progress
- `prog_in`  out  1  serial configuration data to the chain
- `prog_en`  out  1  chain shift enable
- `prog_out`  in  1  serial output of the last chain stage (readback)
- `cfg_done`  out  1  one-cycle pulse at completion (success or verify error)
- `cfg_err`  out  1  sticky: verify mismatch or abort; cleared on the next accept
- `err_idx`  out  clog2(CHAIN_LEN)  bit index of the first mismatch; 0 on abort
- `clb_en`  out  1  fabric enable; high only after a successful configuration

## Operation
- States: IDLE, SHIFT, VERIFY, DONE.
- IDLE: `cfg_ready`=1. On accept, the controller captures `cfg_data` into an internal register, clears `cfg_err`/`err_idx`, drops `clb_en`, and sets bit counter k=0. It enters SHIFT.
- SHIFT: `prog_en`=1 and `prog_in`=bs[k]. Each edge increments k. After the edge on which k=CHAIN_LEN-1 is shifted, k wraps to 0 and the controller enters VERIFY if `VERIFY`=1, else DONE.
- VERIFY: this pass reshifts the same bitstream, with `prog_en`=1 and `prog_in`=bs[k]. On each edge `prog_out` is compared with bs[k]. On the first mismatch, `cfg_err` is set and `err_idx` is set to k, and later mismatches do not change it. The pass runs the full CHAIN_LEN bits regardless of mismatches, so the chain ends holding the intended bitstream. After the last bit, the controller enters DONE.
- DONE: lasts one cycle. `cfg_done`=1 and `prog_en`=0. `clb_en` is set to 1 if `cfg_err`=0 and otherwise stays 0. The controller then returns to IDLE.
- Abort: if `cfg_abort` is high in SHIFT or VERIFY, the controller goes to IDLE at the next edge with `prog_en`=0, `cfg_err`=1 and `err_idx`=0. No `cfg_done` pulse is generated and `clb_en` stays 0. `cfg_abort` is ignored in IDLE. If `cfg_abort` and `cfg_valid` are high together in IDLE, the transfer is not accepted.
- `cfg_ready` is derived from the state (state==IDLE). All other outputs are registered.
- Counter width is clog2(CHAIN_LEN). The counter never exceeds CHAIN_LEN-1.

## Timing
- Reset values: state IDLE, `cfg_ready`=1, `prog_en`=0, `prog_in`=0, `cfg_done`=0, `cfg_err`=0, `err_idx`=0, `clb_en`=0. Reset takes effect immediately, including mid-operation.
- Accept edge E0. After E0, `prog_en`=1 and `prog_in`=bs[0].
- Chain edges E1..E_N (N=CHAIN_LEN) capture bs[0..N-1]. After edge E_k, `prog_in`=bs[k mod N].
- VERIFY=1: edges E_{N+1}..E_{2N} reshift the bitstream. At E_{N+1+j}, `prog_out` must equal bs[j], which assumes FIFO ordering through the chain. `cfg_done` is high for the cycle after E_{2N}. `cfg_ready` rises after E_{2N+1}.
- VERIFY=0: `cfg_done` is high for the cycle after E_N. Total occupancy is N+1 cycles after accept.
- `prog_en` is continuously high for exactly N (or 2N) cycles, with no gaps.
- `clb_en` falls after E0. It rises on the same edge that `cfg_done` rises, and only on success.

## Test plan
- Reset: assert `prog_rst_n`=0 mid-SHIFT. Expected: all outputs return to reset values without a clock edge, and `cfg_ready`=1.
- CHAIN_LEN=8, VERIFY=1, ideal 8-stage chain model, `cfg_data`=8'hA5. Expected: `prog_in` sequence 1,0,1,0,0,1,0,1 appears twice; `prog_en` is high for 16 cycles; `cfg_done` pulses in cycle 17; `cfg_err`=0; `clb_en`=1.
- Same setup with the chain output stuck at 0. Expected: `cfg_err`=1, `err_idx`=0, `cfg_done` pulses in cycle 17, `clb_en`=0.
- 7-stage chain model (one stage short), CHAIN_LEN=8, `cfg_data`=8'h01. Expected: mismatch with `cfg_err`=1 and `err_idx`=0.
- CHAIN_LEN=69, VERIFY=0, arbitrary pattern, `cfg_abort` pulsed after 4 shifts. Expected: `prog_en`=0 on the next edge, `cfg_err`=1, no `cfg_done`, `cfg_ready`=1.
- Hold `cfg_valid` high continuously. Expected: a second accept occurs only in the cycle after DONE, with `cfg_err` cleared on accept. Also drive `cfg_valid` and `cfg_abort` together in IDLE. Expected: not accepted.
